// File: rtl/mem_arbiter_if.sv
// Bundle of request, response and memory-side signals for mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use master.
interface mem_arbiter_if #(
    parameter int DW = 64
) ();
    // Requester side
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [DW-1:0] addr0;
    logic [DW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          busy;

    // Memory side
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port 0 (CPU datapath) and port 1 (loader/debug)
// share one memory. One transaction at a time: IDLE grants, ACCESS drives the
// memory strobes for MEM_LAT cycles, RESP returns a one-cycle completion.
// Ties go to the port not served last; port 0 wins the first tie after reset.
module mem_arbiter #(
    parameter int DW      = 64,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Counter reload: counts down to zero across the ACCESS phase.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic          last_reg;
    logic          owner_reg;
    logic          we_reg;
    logic [DW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;
    logic [3:0]    cnt_reg;

    logic [1:0]    req_vec;
    logic [1:0]    gnt_vec;
    logic [1:0]    rvalid_vec;
    logic          any_req;
    logic          winner;
    logic          sel_we;
    logic [DW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_idle;
    logic          in_access;
    logic          in_resp;

    assign req_vec   = {bus.req1, bus.req0};
    assign in_idle   = (state_reg == IDLE);
    assign in_access = (state_reg == ACCESS);
    assign in_resp   = (state_reg == RESP);

    // Pick the winning port and mux its request fields.
    always_comb begin
        any_req   = |req_vec;
        winner    = 1'b0;
        if (req_vec == 2'b11) begin
            winner = ~last_reg;
        end else begin
            winner = req_vec[1];
        end
        sel_we    = winner ? bus.we1    : bus.we0;
        sel_addr  = winner ? bus.addr1  : bus.addr0;
        sel_wdata = winner ? bus.wdata1 : bus.wdata0;
    end

    // Per-port grant and completion strobes. Grants are gated by rst so a
    // request held through reset is not acknowledged before release.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_vec[gi]    = rst & in_idle & req_vec[gi] & (winner == 1'(gi));
            assign rvalid_vec[gi] = in_resp & (owner_reg == 1'(gi));
        end
    endgenerate

    // Next-state logic for the IDLE -> ACCESS -> RESP cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, captured request, latency counter and response data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (in_idle && any_req) begin
                owner_reg <= winner;
                last_reg  <= winner;
                we_reg    <= sel_we;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                cnt_reg   <= LAT_M1;
            end else if (in_access) begin
                if (cnt_reg == 4'd0) begin
                    rdata_reg <= we_reg ? '0 : bus.mem_rdata;
                end else begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign bus.mem_read  = in_access & ~we_reg;
    assign bus.mem_write = in_access & we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.gnt0      = gnt_vec[0];
    assign bus.gnt1      = gnt_vec[1];
    assign bus.rvalid0   = rvalid_vec[0];
    assign bus.rvalid1   = rvalid_vec[1];
    assign bus.rdata     = rdata_reg;
    assign bus.busy      = ~in_idle;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3.
// Completions are checked against a scoreboard filled at grant time.
module tb_mem_arbiter;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(DW)) bus1 ();
    mem_arbiter_if #(.DW(DW)) bus3 ();

    mem_arbiter #(.DW(DW), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_arbiter #(.DW(DW), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct packed {
        logic          port;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic          port;
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    exp_t sb1[$];
    exp_t sb3[$];
    exp_t e1;
    exp_t e3;
    vec_t vt[5];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [DW-1:0] mem_model(input logic [DW-1:0] a);
        if (a == 64'h40) return 64'hDEAD;
        return {a[31:0], a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    always_comb bus1.mem_rdata = mem_model(bus1.mem_addr);
    always_comb bus3.mem_rdata = mem_model(bus3.mem_addr);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle invariants and scoreboard pops for the MEM_LAT=1 instance.
    always begin
        @(negedge clk);
        #2;
        check("dut1_gnt_onehot", bus1.gnt0 & bus1.gnt1, 0);
        check("dut1_rvalid_onehot", bus1.rvalid0 & bus1.rvalid1, 0);
        check("dut1_strobe_excl", bus1.mem_read & bus1.mem_write, 0);
        if (bus1.rvalid0 || bus1.rvalid1) begin
            if (sb1.size() == 0) begin
                check("dut1_unexpected_rvalid", 1, 0);
            end else begin
                e1 = sb1.pop_front();
                check("dut1_rvalid_port", bus1.rvalid1, e1.port);
                check("dut1_rdata", bus1.rdata, e1.rdata);
                $display("dut1 completion port=%0d rdata=%h", bus1.rvalid1, bus1.rdata);
            end
        end
    end

    // Per-cycle invariants and scoreboard pops for the MEM_LAT=3 instance.
    always begin
        @(negedge clk);
        #2;
        check("dut3_gnt_onehot", bus3.gnt0 & bus3.gnt1, 0);
        check("dut3_rvalid_onehot", bus3.rvalid0 & bus3.rvalid1, 0);
        check("dut3_strobe_excl", bus3.mem_read & bus3.mem_write, 0);
        if (bus3.rvalid0 || bus3.rvalid1) begin
            if (sb3.size() == 0) begin
                check("dut3_unexpected_rvalid", 1, 0);
            end else begin
                e3 = sb3.pop_front();
                check("dut3_rvalid_port", bus3.rvalid1, e3.port);
                check("dut3_rdata", bus3.rdata, e3.rdata);
                $display("dut3 completion port=%0d rdata=%h", bus3.rvalid1, bus3.rdata);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // One table transaction on the MEM_LAT=1 instance: grant, access, response.
    task automatic run_vec1(input vec_t v);
        @(negedge clk);
        if (v.port) begin
            bus1.req1 = 1'b1; bus1.we1 = v.we; bus1.addr1 = v.addr; bus1.wdata1 = v.wdata;
        end else begin
            bus1.req0 = 1'b1; bus1.we0 = v.we; bus1.addr0 = v.addr; bus1.wdata0 = v.wdata;
        end
        #1;
        check("vec_gnt0", bus1.gnt0, !v.port);
        check("vec_gnt1", bus1.gnt1, v.port);
        sb1.push_back('{port: v.port, rdata: v.exp_rdata});
        $display("vec port=%0d we=%0d addr=%h wdata=%h", v.port, v.we, v.addr, v.wdata);
        @(negedge clk);
        bus1.req0 = 1'b0;
        bus1.req1 = 1'b0;
        #1;
        check("vec_mem_read", bus1.mem_read, !v.we);
        check("vec_mem_write", bus1.mem_write, v.we);
        check("vec_mem_addr", bus1.mem_addr, v.addr);
        check("vec_mem_wdata", bus1.mem_wdata, v.wdata);
        check("vec_busy_access", bus1.busy, 1);
        @(negedge clk);
        #1;
        check("vec_rvalid", v.port ? bus1.rvalid1 : bus1.rvalid0, 1);
        check("vec_strobes_resp", bus1.mem_read | bus1.mem_write, 0);
    endtask

    initial begin
        {bus1.req0, bus1.req1, bus1.we0, bus1.we1} = '0;
        {bus3.req0, bus3.req1, bus3.we0, bus3.we1} = '0;
        bus1.addr0 = '0; bus1.addr1 = '0; bus1.wdata0 = '0; bus1.wdata1 = '0;
        bus3.addr0 = '0; bus3.addr1 = '0; bus3.wdata0 = '0; bus3.wdata1 = '0;

        vt[0] = '{1'b0, 1'b0, 64'h40,                  64'h0,       64'hDEAD};
        vt[1] = '{1'b1, 1'b0, 64'h100,                 64'h0,       mem_model(64'h100)};
        vt[2] = '{1'b0, 1'b1, 64'h20,                  64'h1234,    64'h0};
        vt[3] = '{1'b1, 1'b1, 64'h8,                   64'h55,      64'h0};
        vt[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hABCD,    mem_model(64'hFFFF_FFFF_FFFF_FFF8)};

        // Reset: request held high must not be granted while rst is low.
        bus1.req0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt0", bus1.gnt0, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_strobes", bus1.mem_read | bus1.mem_write, 0);
        check("rst_rvalid", bus1.rvalid0 | bus1.rvalid1, 0);
        check("rst_rdata", bus1.rdata, 0);
        check("rst_mem_addr", bus1.mem_addr, 0);
        check("rst_mem_wdata", bus1.mem_wdata, 0);
        check("rst_busy3", bus3.busy, 0);
        bus1.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Both ports held: grants alternate 0,1,0,1 every 3 cycles.
        @(negedge clk);
        bus1.addr0 = 64'h40; bus1.addr1 = 64'h200;
        bus1.req0 = 1'b1; bus1.req1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("alt_gnt0", bus1.gnt0, (c % 3 == 0) && ((c / 3) % 2 == 0));
            check("alt_gnt1", bus1.gnt1, (c % 3 == 0) && ((c / 3) % 2 == 1));
            if (c % 3 == 0) begin
                if ((c / 3) % 2 == 1) sb1.push_back('{port: 1'b1, rdata: mem_model(64'h200)});
                else                  sb1.push_back('{port: 1'b0, rdata: 64'hDEAD});
                $display("alt cycle=%0d expect grant port=%0d", c, (c / 3) % 2);
            end
        end
        @(negedge clk);
        bus1.req0 = 1'b0; bus1.req1 = 1'b0;

        // Table-driven single transactions, back to back.
        for (int i = 0; i < 5; i++) run_vec1(vt[i]);

        // Port 1 raises then drops req while port 0 is being served.
        @(negedge clk);
        bus1.req0 = 1'b1; bus1.we0 = 1'b0; bus1.addr0 = 64'h500;
        #1;
        check("drop_gnt0", bus1.gnt0, 1);
        sb1.push_back('{port: 1'b0, rdata: mem_model(64'h500)});
        @(negedge clk);
        bus1.req0 = 1'b0; bus1.req1 = 1'b1; bus1.addr1 = 64'h600;
        #1;
        check("drop_gnt1_access", bus1.gnt1, 0);
        @(negedge clk);
        bus1.req1 = 1'b0;
        #1;
        check("drop_gnt1_resp", bus1.gnt1, 0);
        check("drop_rvalid0", bus1.rvalid0, 1);
        @(negedge clk);
        #1;
        check("drop_gnt1_idle", bus1.gnt1, 0);
        check("drop_idle_busy", bus1.busy, 0);
        $display("drop sequence done");

        // MEM_LAT=3 read of 0x40, then write 0x55 to 0x8 from port 1.
        @(negedge clk);
        bus3.req0 = 1'b1; bus3.we0 = 1'b0; bus3.addr0 = 64'h40;
        #1;
        check("l3_rd_gnt0", bus3.gnt0, 1);
        sb3.push_back('{port: 1'b0, rdata: 64'hDEAD});
        @(negedge clk);
        bus3.req0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("l3_rd_mem_read", bus3.mem_read, 1);
            check("l3_rd_mem_addr", bus3.mem_addr, 64'h40);
        end
        @(negedge clk);
        #1;
        check("l3_rd_rvalid0", bus3.rvalid0, 1);
        check("l3_rd_strobe_off", bus3.mem_read, 0);

        @(negedge clk);
        bus3.req1 = 1'b1; bus3.we1 = 1'b1; bus3.addr1 = 64'h8; bus3.wdata1 = 64'h55;
        #1;
        check("l3_wr_gnt1", bus3.gnt1, 1);
        sb3.push_back('{port: 1'b1, rdata: 64'h0});
        @(negedge clk);
        bus3.req1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("l3_wr_mem_write", bus3.mem_write, 1);
            check("l3_wr_mem_addr", bus3.mem_addr, 64'h8);
            check("l3_wr_mem_wdata", bus3.mem_wdata, 64'h55);
        end
        @(negedge clk);
        #1;
        check("l3_wr_rvalid1", bus3.rvalid1, 1);
        check("l3_wr_rdata", bus3.rdata, 0);
        check("l3_wr_strobe_off", bus3.mem_write, 0);
        @(negedge clk);
        #1;
        check("l3_wr_idle", bus3.busy, 0);

        // Reset during the second ACCESS cycle aborts without a completion.
        @(negedge clk);
        bus3.req0 = 1'b1; bus3.we0 = 1'b0; bus3.addr0 = 64'h300;
        #1;
        check("abort_gnt0", bus3.gnt0, 1);
        @(negedge clk);
        bus3.req0 = 1'b0;
        #1;
        check("abort_access1", bus3.mem_read, 1);
        @(negedge clk);
        #1;
        check("abort_access2", bus3.mem_read, 1);
        rst = 1'b0;
        #1;
        check("abort_strobe_drop", bus3.mem_read, 0);
        check("abort_busy", bus3.busy, 0);
        check("abort_rvalid", bus3.rvalid0 | bus3.rvalid1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus3.req1 = 1'b1; bus3.we1 = 1'b0; bus3.addr1 = 64'h10;
        #1;
        check("post_abort_gnt1", bus3.gnt1, 1);
        sb3.push_back('{port: 1'b1, rdata: mem_model(64'h10)});
        @(negedge clk);
        bus3.req1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("post_abort_rvalid1", bus3.rvalid1, 1);

        repeat (3) @(negedge clk);
        #3;
        check("sb1_drained", sb1.size(), 0);
        check("sb3_drained", sb3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DW, 64, address and data width.
REQ-002 Parameter: MEM_LAT, 1, memory access cycles (legal 1..15).
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: req0 / req1  in  1 each  access request; port 0 = CPU datapath, port 1 = loader/debug.
REQ-006 Port: we0 / we1  in  1 each  1 = write, 0 = read.
REQ-007 Port: addr0 / addr1  in  DW each  byte address.
REQ-008 Port: wdata0 / wdata1  in  DW each  write data.
REQ-009 Port: gnt0 / gnt1  out  1 each  request accepted this cycle.
REQ-010 Port: rvalid0 / rvalid1  out  1 each  one-cycle completion strobe, for reads and writes.
REQ-011 Port: rdata  out  DW  read data, valid while rvalid0 or rvalid1 is high.
REQ-012 Port: mem_read / mem_write  out  1 each  memory strobes.
REQ-013 Port: mem_addr / mem_wdata  out  DW each  memory address and write data.
REQ-014 Port: mem_rdata  in  DW  memory read data, sampled on the last ACCESS cycle.
REQ-015 Port: busy  out  1  high in ACCESS or RESP.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-017 In IDLE with any req high, exactly one gnt SHALL be asserted combinationally in that cycle; the edge that ends the cycle captures the winner's we/addr/wdata and owner id, then moves to ACCESS.
REQ-018 With one requester active, it SHALL win; with both active, the port not served last SHALL win; after reset, port 0 wins the first tie.
REQ-019 gnt0 and gnt1 SHALL never be high together and SHALL be low outside IDLE.
REQ-020 In ACCESS, mem_addr/mem_wdata SHALL come from captured registers; mem_read = ~we_q, mem_write = we_q, held for exactly MEM_LAT cycles counted by a down-counter.
REQ-021 On the last ACCESS cycle, the edge SHALL register mem_rdata into rdata for reads (rdata = 0 for writes), and the FSM SHALL move to RESP.
REQ-022 In RESP, the owner's rvalid SHALL be high for exactly one cycle with strobes low; next state IDLE.
REQ-023 Throughput SHALL be one transaction per MEM_LAT+2 cycles; a grant is possible in the first IDLE cycle after RESP.
REQ-024 req changes during ACCESS/RESP SHALL be ignored; an ungranted requester may drop req with no effect.
REQ-025 mem_addr/mem_wdata SHALL hold the last captured values in IDLE; strobes SHALL be low in IDLE and RESP.
REQ-026 A requester holding req high after its rvalid SHALL be treated as a new request.

Reset
REQ-027 While rst is low: state IDLE, gnt0/gnt1/rvalid0/rvalid1/mem_read/mem_write/busy = 0, rdata/mem_addr/mem_wdata = 0, last-served = port 1 (so port 0 wins the first tie), counter = 0.
REQ-028 rst asserted mid-ACCESS or mid-RESP SHALL abort immediately (strobes drop asynchronously), with no rvalid issued for the aborted transaction.
REQ-029 The first grant after reset release SHALL occur no earlier than the first rising edge with rst high.

Verification
REQ-030 MEM_LAT=1, req0 read addr 0x40, memory returns 0xDEAD -> gnt0 in cycle 0, mem_read in cycle 1, rvalid0 with rdata=0xDEAD in cycle 2.
REQ-031 Both req held, first tie after reset -> grants alternate 0,1,0,1, each MEM_LAT+2 cycles apart.
REQ-032 MEM_LAT=3, req1 write addr 0x8 data 0x55 -> mem_write high for exactly 3 cycles with mem_addr=0x8, mem_wdata=0x55, then rvalid1 with rdata=0.
REQ-033 rst pulled low during the second ACCESS cycle -> strobes low immediately, no rvalid, and the next request after release is granted normally.
REQ-034 req1 raised then dropped while port 0 is in ACCESS -> no gnt1 ever, and port 0's completion is unaffected.
REQ-035 Throughout all scenarios, assert gnt one-hot-or-zero, rvalid one-hot-or-zero, and that mem_read and mem_write are never high together.
